// File: rtl/qupls_alu_issue_steer_pkg.sv
`default_nettype none
// ============================================================================
// Module : QuplsPkg
// Brief  : Shared types for the ALU issue steering queue.
// Rev    : 1.0
// ============================================================================
package QuplsPkg;

  typedef logic [31:0] instruction_t;

  localparam int ALU_ISSUE_DEPTH = 8;
  localparam int ALU_ISSUE_TAGW  = 6;
  localparam int ALU_ISSUE_LATW  = 4;

  typedef struct packed {
    instruction_t              instr;
    logic [ALU_ISSUE_TAGW-1:0] tag;
    logic                      alu0;
    logic [ALU_ISSUE_LATW-1:0] lat;
    logic                      v;
  } alu_issue_ent_t;

endpackage
`default_nettype wire

// File: rtl/qupls_alu0_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module : qupls_alu0_busy_ctr
// Brief  : Counts down the remaining ALU0 occupancy of a multi-cycle op.
// Rev    : 1.0
// ============================================================================
module qupls_alu0_busy_ctr
  import QuplsPkg::*;
#(
  parameter int LATW = ALU_ISSUE_LATW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LATW-1:0] lat,
  output logic [LATW-1:0] busy_cnt,
  output logic            busy
);

  logic [LATW-1:0] r_cnt;

  // The issue cycle itself is the first occupied cycle, so L cycles load L-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (lat == '0) ? '0 : lat - LATW'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LATW'(1);
    end
  end

  assign busy_cnt = r_cnt;
  assign busy     = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/qupls_alu_issue_steer.sv
`default_nettype none
// ============================================================================
// Module : qupls_alu_issue_steer
// Brief  : In-order decoded-op queue steering up to two ops/cycle to ALU0/ALU1.
// Rev    : 1.0
// ============================================================================
module qupls_alu_issue_steer
  import QuplsPkg::*;
#(
  parameter int DEPTH = ALU_ISSUE_DEPTH,
  parameter int TAGW  = ALU_ISSUE_TAGW,
  parameter int LATW  = ALU_ISSUE_LATW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  instruction_t      in_instr,
  input  logic [TAGW-1:0]   in_tag,
  input  logic              in_alu0,
  input  logic [LATW-1:0]   in_lat,
  output logic              alu0_valid,
  output instruction_t      alu0_instr,
  output logic [TAGW-1:0]   alu0_tag,
  output logic              alu1_valid,
  output instruction_t      alu1_instr,
  output logic [TAGW-1:0]   alu1_tag,
  output logic              alu0_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_issue_ent_t  r_q [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_rd1;
  alu_issue_ent_t  w_h;
  alu_issue_ent_t  w_n;
  alu_issue_ent_t  w_ent;
  logic            w_hv, w_nv, w_free;
  logic            w_h0, w_h1, w_n0, w_n1;
  logic            w_push, w_load;
  logic [1:0]      w_pop;
  logic [LATW-1:0] w_lat;
  logic [LATW-1:0] w_busy_cnt;
  logic            w_busy;

  assign in_ready = (r_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready && !flush;

  assign w_ent.instr = in_instr;
  assign w_ent.tag   = in_tag;
  assign w_ent.alu0  = in_alu0;
  assign w_ent.lat   = in_lat;
  assign w_ent.v     = 1'b1;

  assign w_rd1 = r_rd + PW'(1);
  assign w_h   = r_q[r_rd];
  assign w_n   = r_q[w_rd1];
  assign w_hv  = (r_count != '0) && w_h.v;
  assign w_nv  = (r_count > CW'(1)) && w_n.v;
  assign w_free = (w_busy_cnt == '0);

  // H+1 may only ride along on whichever ALU the head left unused.
  assign w_h0 = !flush && w_hv && w_h.alu0 && w_free;
  assign w_h1 = !flush && w_hv && !w_h.alu0;
  assign w_n0 = w_h1 && w_nv && w_n.alu0 && w_free;
  assign w_n1 = w_h0 && w_nv && !w_n.alu0;

  assign w_pop  = {1'b0, (w_h0 | w_h1)} + {1'b0, (w_n0 | w_n1)};
  assign w_load = w_h0 | w_n0;
  assign w_lat  = w_h0 ? w_h.lat : w_n.lat;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wr] <= w_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= r_rd + PW'(w_pop);
      r_wr    <= r_wr + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu0_valid <= 1'b0;
      alu0_instr <= '0;
      alu0_tag   <= '0;
      alu1_valid <= 1'b0;
      alu1_instr <= '0;
      alu1_tag   <= '0;
    end else begin
      alu0_valid <= w_h0 | w_n0;
      alu1_valid <= w_h1 | w_n1;
      if (w_h0) begin
        alu0_instr <= w_h.instr;
        alu0_tag   <= w_h.tag;
      end else if (w_n0) begin
        alu0_instr <= w_n.instr;
        alu0_tag   <= w_n.tag;
      end
      if (w_h1) begin
        alu1_instr <= w_h.instr;
        alu1_tag   <= w_h.tag;
      end else if (w_n1) begin
        alu1_instr <= w_n.instr;
        alu1_tag   <= w_n.tag;
      end
    end
  end

  qupls_alu0_busy_ctr #(
    .LATW (LATW)
  ) u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .lat      (w_lat),
    .busy_cnt (w_busy_cnt),
    .busy     (w_busy)
  );

  assign alu0_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_qupls_alu_issue_steer.sv
`default_nettype none
// ============================================================================
// Module : tb_qupls_alu_issue_steer
// Brief  : Directed scoreboard bench for the ALU issue steering queue.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_qupls_alu_issue_steer;
  import QuplsPkg::*;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         flush    = 1'b0;
  logic         in_valid = 1'b0;
  instruction_t in_instr = '0;
  logic [5:0]   in_tag   = '0;
  logic         in_alu0  = 1'b0;
  logic [3:0]   in_lat   = '0;
  logic         in_ready;
  logic         alu0_valid, alu1_valid, alu0_busy;
  instruction_t alu0_instr, alu1_instr;
  logic [5:0]   alu0_tag, alu1_tag;

  int n_vec  = 0;
  int n_miss = 0;
  logic [37:0] exp0 [$];
  logic [37:0] exp1 [$];

  localparam logic [31:0] I_ADD = 32'h0000_1001;
  localparam logic [31:0] I_SUB = 32'h0000_2002;
  localparam logic [31:0] I_MUL = 32'h0000_3003;
  localparam logic [31:0] I_DIV = 32'h0000_4004;
  localparam logic [31:0] I_MLI = 32'h0000_5005;

  qupls_alu_issue_steer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .in_alu0    (in_alu0),
    .in_lat     (in_lat),
    .alu0_valid (alu0_valid),
    .alu0_instr (alu0_instr),
    .alu0_tag   (alu0_tag),
    .alu1_valid (alu1_valid),
    .alu1_instr (alu1_instr),
    .alu1_tag   (alu1_tag),
    .alu0_busy  (alu0_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {37'b0, act}, {37'b0, exp});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Non-ALU0 ops always land on ALU1, ALU0-only ops on ALU0, in program order.
  task automatic push(input logic [31:0] ins, input logic [5:0] tag, input logic a0,
                      input logic [3:0] lat);
    chkb("in_ready_before_push", in_ready, 1'b1);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
    in_alu0  = a0;
    in_lat   = lat;
    if (a0) exp0.push_back({ins, tag});
    else    exp1.push_back({ins, tag});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && k < 80) begin
      cyc(1);
      k++;
    end
    @(negedge clk);
    #1;
    chk(name, 38'(exp0.size() + exp1.size()), 38'd0);
    k = 0;
    while (alu0_busy && k < 20) begin
      cyc(1);
      k++;
    end
    chkb({name, "_busy_clear"}, alu0_busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu0_valid) begin
        if (exp0.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL alu0_extra: got tag %0d expected no issue", alu0_tag);
        end else begin
          chk("alu0_op", {alu0_instr, alu0_tag}, exp0.pop_front());
        end
      end
      if (alu1_valid) begin
        if (exp1.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL alu1_extra: got tag %0d expected no issue", alu1_tag);
        end else begin
          chk("alu1_op", {alu1_instr, alu1_tag}, exp1.pop_front());
        end
      end
    end
  end

  initial begin
    cyc(3);
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_alu0_valid", alu0_valid, 1'b0);
    chkb("rst_alu1_valid", alu1_valid, 1'b0);
    chkb("rst_busy", alu0_busy, 1'b0);
    chk("rst_alu0_out", {alu0_instr, alu0_tag}, 38'd0);
    chk("rst_alu1_out", {alu1_instr, alu1_tag}, 38'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single ADD: visible on ALU1 one edge after the push edge.
    push(I_ADD, 6'd1, 1'b0, 4'd0);
    chkb("add_not_yet", alu1_valid, 1'b0);
    cyc(1);
    chkb("add_alu1_valid", alu1_valid, 1'b1);
    chkb("add_alu0_idle", alu0_valid, 1'b0);
    chk("add_tag", {32'b0, alu1_tag}, 38'd1);
    cyc(1);
    chkb("add_single", alu1_valid, 1'b0);
    cyc(2);

    // DIV lat 10 then MULI lat 3.
    push(I_DIV, 6'd2, 1'b1, 4'd10);
    push(I_MLI, 6'd3, 1'b1, 4'd3);
    chkb("div_issue", alu0_valid, 1'b1);
    chk("div_tag", {32'b0, alu0_tag}, 38'd2);
    chkb("div_busy_1", alu0_busy, 1'b1);
    for (int i = 2; i <= 9; i++) begin
      cyc(1);
      chkb("div_busy_n", alu0_busy, 1'b1);
      chkb("muli_stalled", alu0_valid, 1'b0);
    end
    cyc(1);
    chkb("div_busy_done", alu0_busy, 1'b0);
    chkb("muli_not_yet", alu0_valid, 1'b0);
    cyc(1);
    chkb("muli_issue", alu0_valid, 1'b1);
    chk("muli_tag", {32'b0, alu0_tag}, 38'd3);
    drain("div_muli_drain");

    // Stall the queue behind a busy ALU0, then release into two dual-issue cycles.
    push(I_DIV, 6'd10, 1'b1, 4'd4);
    push(I_MUL, 6'd11, 1'b1, 4'd1);
    push(I_SUB, 6'd12, 1'b0, 4'd0);
    push(I_ADD, 6'd13, 1'b0, 4'd0);
    push(I_MUL, 6'd14, 1'b1, 4'd1);
    chkb("dual_pre_idle", alu0_valid, 1'b0);
    cyc(1);
    chkb("dual1_alu0", alu0_valid, 1'b1);
    chkb("dual1_alu1", alu1_valid, 1'b1);
    chk("dual1_tags", {26'b0, alu0_tag, alu1_tag}, {26'b0, 6'd11, 6'd12});
    cyc(1);
    chkb("dual2_alu0", alu0_valid, 1'b1);
    chkb("dual2_alu1", alu1_valid, 1'b1);
    chk("dual2_tags", {26'b0, alu0_tag, alu1_tag}, {26'b0, 6'd14, 6'd13});
    cyc(1);
    chkb("dual_done", alu0_valid | alu1_valid, 1'b0);
    drain("dual_drain");

    // Two general ops issue singly, in order.
    push(I_ADD, 6'd20, 1'b0, 4'd0);
    push(I_SUB, 6'd21, 1'b0, 4'd0);
    chk("seq_first", {31'b0, alu1_valid, alu1_tag}, {31'b0, 1'b1, 6'd20});
    cyc(1);
    chk("seq_second", {31'b0, alu1_valid, alu1_tag}, {31'b0, 1'b1, 6'd21});
    chkb("seq_alu0_idle", alu0_valid, 1'b0);
    cyc(1);
    chkb("seq_done", alu1_valid, 1'b0);
    drain("seq_drain");

    // Fill all entries behind a stalled ALU0-only head.
    push(I_DIV, 6'd30, 1'b1, 4'd12);
    push(I_MUL, 6'd31, 1'b1, 4'd1);
    push(I_ADD, 6'd32, 1'b0, 4'd0);
    push(I_SUB, 6'd33, 1'b0, 4'd0);
    push(I_MUL, 6'd34, 1'b1, 4'd1);
    push(I_ADD, 6'd35, 1'b0, 4'd0);
    push(I_MLI, 6'd36, 1'b1, 4'd2);
    push(I_SUB, 6'd37, 1'b0, 4'd0);
    push(I_ADD, 6'd38, 1'b0, 4'd0);
    chkb("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_instr = I_ADD;
    in_tag   = 6'd39;
    in_alu0  = 1'b0;
    in_lat   = 4'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chkb("full_still", in_ready, 1'b0);
    chkb("full_no_issue", alu1_valid, 1'b0);
    drain("full_drain");

    // Flush with a concurrent push while ALU0 is still busy.
    push(I_DIV, 6'd40, 1'b1, 4'd9);
    push(I_MUL, 6'd41, 1'b1, 4'd1);
    push(I_ADD, 6'd42, 1'b0, 4'd0);
    push(I_SUB, 6'd43, 1'b0, 4'd0);
    push(I_MUL, 6'd44, 1'b1, 4'd1);
    push(I_ADD, 6'd45, 1'b0, 4'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = I_ADD;
    in_tag   = 6'd46;
    in_alu0  = 1'b0;
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chkb("flush_alu0", alu0_valid, 1'b0);
    chkb("flush_alu1", alu1_valid, 1'b0);
    chkb("flush_ready", in_ready, 1'b1);
    chkb("flush_busy3", alu0_busy, 1'b1);
    cyc(1);
    chkb("flush_busy2", alu0_busy, 1'b1);
    cyc(1);
    chkb("flush_busy1", alu0_busy, 1'b1);
    cyc(1);
    chkb("flush_busy0", alu0_busy, 1'b0);
    push(I_ADD, 6'd47, 1'b0, 4'd0);
    drain("post_flush_drain");

    // Asynchronous reset in the middle of a busy period.
    push(I_DIV, 6'd50, 1'b1, 4'd15);
    cyc(2);
    push(I_MUL, 6'd52, 1'b1, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("arst_busy", alu0_busy, 1'b0);
    chkb("arst_alu0", alu0_valid, 1'b0);
    chkb("arst_ready", in_ready, 1'b1);
    chk("arst_tag", {32'b0, alu0_tag}, 38'd0);
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chkb("arst_no_issue", alu0_valid | alu1_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
